// File: rtl/patch_pkg.sv
// Shared types and scan-geometry helpers for patch_window_loader.
// Optional feature: define ZERO_PAD_EN for "same" padding (centre-pixel scan over the full image).
package patch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    STEP,
    DRAIN,
    OFFER,
    DONE
  } state_t;

`ifdef ZERO_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  // Rows/columns above/left of the patch coordinate that the window reaches.
  function automatic int pad_off(input int k);
    return PAD_EN ? (k - 1) / 2 : 0;
  endfunction

  // Last patch coordinate along one image dimension.
  function automatic int last_pos(input int k, input int dim);
    return PAD_EN ? dim - 1 : dim - k;
  endfunction

  // Patches in one full image scan.
  function automatic int patch_cnt(input int k, input int w, input int h);
    return (last_pos(k, w) + 1) * (last_pos(k, h) + 1);
  endfunction

  // Memory address of the first pixel of image row y.
  function automatic int row_base(input int y, input int img_w);
    return y * img_w;
  endfunction

endpackage

// File: rtl/patch_row_shifter.sv
// K-row by K-pixel window storage. Each capture shifts rows up by one and
// loads the newest memory row at the bottom; masked ports load zero.
module patch_row_shifter #(
  parameter int DATA_W = 8,
  parameter int K      = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cap,
  input  logic [K-1:0]            mask,
  input  logic [K*DATA_W-1:0]     row_in,
  output logic [K*K*DATA_W-1:0]   patch
);

  logic [K*DATA_W-1:0] rows [K];
  logic [K*DATA_W-1:0] row_m;

  // Zero the pixels of ports that addressed outside the image.
  always_comb begin
    row_m = row_in;
    for (int j = 0; j < K; j++) begin
      if (mask[j]) row_m[j*DATA_W +: DATA_W] = '0;
    end
  end

  // Shift the window up one row and append the freshly read row.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < K; r++) rows[r] <= '0;
    end else if (cap) begin
      for (int r = 0; r < K-1; r++) rows[r] <= rows[r+1];
      rows[K-1] <= row_m;
    end
  end

  // Flatten: row r, column c at bits [(r*K+c)*DATA_W +: DATA_W].
  always_comb begin
    patch = '0;
    for (int r = 0; r < K; r++) patch[r*K*DATA_W +: K*DATA_W] = rows[r];
  end

endmodule

// File: rtl/patch_window_loader.sv
// KxK sliding-window patch loader: column-major scan, K parallel read ports,
// one new row per vertical step, valid/ready patch output.
// Optional feature: define ZERO_PAD_EN for "same" padding with per-port zero mask.
module patch_window_loader
  import patch_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int K      = 3,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   mem_rd_en,
  output logic [K*ADDR_W-1:0]    mem_addr,
  input  logic [K*DATA_W-1:0]    mem_data,
  output logic [K*K*DATA_W-1:0]  patch,
  output logic                   patch_valid,
  input  logic                   patch_ready,
  output logic [ADDR_W-1:0]      patch_x,
  output logic [ADDR_W-1:0]      patch_y,
  output logic                   busy,
  output logic                   done
);

  localparam int LAST_X = last_pos(K, IMG_W);
  localparam int LAST_Y = last_pos(K, IMG_H);
  localparam int OFF    = pad_off(K);
  localparam int CW     = $clog2(K + 1);

  state_t            state;
  logic [CW-1:0]     fcnt;
  logic [ADDR_W-1:0] x;
  logic [ADDR_W-1:0] y;
  logic              last;
  logic              iss;
  int                iss_ry;
  int                iss_cx;
  logic              cap_p1;
  logic [K-1:0]      cap_mask;

  assign last = (x == ADDR_W'(LAST_X)) && (y == ADDR_W'(LAST_Y));

  // Port j reads column cx-OFF+j of image row ry; out-of-image ports read address 0.
  function automatic logic [K*ADDR_W-1:0] addr_vec(input int ry, input int cx);
    logic [K*ADDR_W-1:0] v;
    int col;
    v = '0;
    for (int j = 0; j < K; j++) begin
      col = cx - OFF + j;
      if (ry >= 0 && ry < IMG_H && col >= 0 && col < IMG_W)
        v[j*ADDR_W +: ADDR_W] = ADDR_W'(row_base(ry, IMG_W) + col);
    end
    return v;
  endfunction

  // Decide whether a row read is issued on the coming edge, and which row/column.
  always_comb begin
    iss    = 1'b0;
    iss_ry = 0;
    iss_cx = int'(x);
    case (state)
      IDLE: if (start) begin
        iss    = 1'b1;
        iss_ry = -OFF;
        iss_cx = 0;
      end
      FILL: if (fcnt != CW'(K-1)) begin
        iss    = 1'b1;
        iss_ry = int'(y) - OFF + int'(fcnt) + 1;
      end
      OFFER: if (patch_ready && !last) begin
        iss = 1'b1;
        if (y < ADDR_W'(LAST_Y)) begin
          iss_ry = int'(y) + K - OFF;
        end else begin
          iss_ry = -OFF;
          iss_cx = int'(x) + 1;
        end
      end
      default: ;
    endcase
  end

  // Address issue (p0) and capture strobe one edge after the memory registers it (p1).
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      cap_p1    <= 1'b0;
    end else begin
      mem_rd_en <= iss;
      mem_addr  <= iss ? addr_vec(iss_ry, iss_cx) : '0;
      cap_p1    <= mem_rd_en;
    end
  end

`ifdef ZERO_PAD_EN
  logic [K-1:0] mask_p0;
  logic [K-1:0] mask_p1;

  function automatic logic [K-1:0] mask_vec(input int ry, input int cx);
    logic [K-1:0] m;
    int col;
    m = '0;
    for (int j = 0; j < K; j++) begin
      col  = cx - OFF + j;
      m[j] = !(ry >= 0 && ry < IMG_H && col >= 0 && col < IMG_W);
    end
    return m;
  endfunction

  // Out-of-image mask travels with the read so it lines up with the returned row.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mask_p0 <= '0;
      mask_p1 <= '0;
    end else begin
      mask_p0 <= iss ? mask_vec(iss_ry, iss_cx) : '0;
      mask_p1 <= mask_p0;
    end
  end

  assign cap_mask = mask_p1;
`else
  assign cap_mask = '0;
`endif

  // Scan controller: fill/step the window, offer the patch, advance the scan position.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      fcnt        <= '0;
      x           <= '0;
      y           <= '0;
      patch_valid <= 1'b0;
      patch_x     <= '0;
      patch_y     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= FILL;
          busy  <= 1'b1;
          x     <= '0;
          y     <= '0;
          fcnt  <= '0;
        end
        FILL: begin
          if (fcnt == CW'(K-1)) state <= DRAIN;
          else                  fcnt  <= fcnt + CW'(1);
        end
        STEP:  state <= DRAIN;
        DRAIN: begin
          state       <= OFFER;
          patch_valid <= 1'b1;
          patch_x     <= x;
          patch_y     <= y;
        end
        OFFER: if (patch_ready) begin
          patch_valid <= 1'b0;
          if (last) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (y < ADDR_W'(LAST_Y)) begin
            y     <= y + ADDR_W'(1);
            state <= STEP;
          end else begin
            y     <= '0;
            x     <= x + ADDR_W'(1);
            fcnt  <= '0;
            state <= FILL;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  patch_row_shifter #(
    .DATA_W (DATA_W),
    .K      (K)
  ) u_shifter (
    .clk    (clk),
    .rst    (rst),
    .cap    (cap_p1),
    .mask   (cap_mask),
    .row_in (mem_data),
    .patch  (patch)
  );

endmodule
